// File: rtl/uart_rx_pkg.sv
// Shared UART RX constants and helpers used by the sampler, the RX FSM and the checkers.
// Latency: none (constants and pure functions only).
// Backpressure: none; nothing in this package carries flow control.
// Contents: default oversampling/counter sizing, idle line level, frame bit indices,
//           and the 3-sample majority and unanimity helpers.
package uart_rx_pkg;

   localparam int PRESCALE_DEF = 8;
   localparam int EDGE_W_DEF   = 4;
   localparam int BIT_W_DEF    = 4;

   localparam logic IDLE_LINE = 1'b1;

   // Frame bit indices as seen on BIT_COUNT; the RX FSM decodes against these.
   localparam logic [BIT_W_DEF-1:0] START_BIT    = 4'd0;
   localparam logic [BIT_W_DEF-1:0] FIRST_DATA   = 4'd1;
   localparam logic [BIT_W_DEF-1:0] PARITY_BIT   = 4'd9;
   localparam logic [BIT_W_DEF-1:0] STOP_BIT_PAR = 4'd10;

   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

   function automatic logic unanimous3(input logic [2:0] s);
      return (s == 3'b000) || (s == 3'b111);
   endfunction

endpackage

// File: rtl/rx_data_sampler_if.sv
// Bundle between the RX FSM / checkers and the data sampler.
// Latency: wires only.
// Backpressure: none; the FSM enables are level controls and SAMPLE_VALID is a one-cycle strobe.
// Signals: RX_IN (raw line), COUNTER_EN / DATA_SAMP_EN (FSM controls), RX_SYNC, EDGE_COUNT,
//          BIT_COUNT, SAMPLED_BIT, SAMPLE_VALID, NOISE_FLAG (sampler results).
//          master = FSM/line side, slave = sampler.
interface rx_data_sampler_if import uart_rx_pkg::*; #(
   parameter int EDGE_W = EDGE_W_DEF,
   parameter int BIT_W  = BIT_W_DEF
);
   logic              RX_IN;
   logic              COUNTER_EN;
   logic              DATA_SAMP_EN;
   logic              RX_SYNC;
   logic [EDGE_W-1:0] EDGE_COUNT;
   logic [BIT_W-1:0]  BIT_COUNT;
   logic              SAMPLED_BIT;
   logic              SAMPLE_VALID;
   logic              NOISE_FLAG;

   modport master (
      output RX_IN, COUNTER_EN, DATA_SAMP_EN,
      input  RX_SYNC, EDGE_COUNT, BIT_COUNT, SAMPLED_BIT, SAMPLE_VALID, NOISE_FLAG
   );

   modport slave (
      input  RX_IN, COUNTER_EN, DATA_SAMP_EN,
      output RX_SYNC, EDGE_COUNT, BIT_COUNT, SAMPLED_BIT, SAMPLE_VALID, NOISE_FLAG
   );
endinterface

// File: rtl/rx_edge_bit_counter.sv
// Oversample edge counter and frame bit counter for the UART receiver.
// Latency: registered; counts update one CLK after the enable is seen.
// Backpressure: none; COUNTER_EN low clears both counts on the next edge.
// Ports: CLK, RST (sync, active-low), COUNTER_EN in; EDGE_COUNT (0..PRESCALE-1) and
//        BIT_COUNT (saturating, start bit = 0) out.
module rx_edge_bit_counter import uart_rx_pkg::*; #(
   parameter int PRESCALE = PRESCALE_DEF,
   parameter int EDGE_W   = EDGE_W_DEF,
   parameter int BIT_W    = BIT_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              COUNTER_EN,
   output logic [EDGE_W-1:0] EDGE_COUNT,
   output logic [BIT_W-1:0]  BIT_COUNT
);

   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(PRESCALE - 1);
   localparam logic [BIT_W-1:0]  BIT_MAX   = {BIT_W{1'b1}};

   always_ff @(posedge CLK) begin
      if (!RST || !COUNTER_EN) begin
         EDGE_COUNT <= '0;
         BIT_COUNT  <= '0;
      end else if (EDGE_COUNT == LAST_EDGE) begin
         EDGE_COUNT <= '0;
         // Saturate so an over-long frame can never alias back onto the start bit.
         if (BIT_COUNT != BIT_MAX) begin
            BIT_COUNT <= BIT_COUNT + 1'b1;
         end
      end else begin
         EDGE_COUNT <= EDGE_COUNT + 1'b1;
      end
   end

endmodule

// File: rtl/rx_data_sampler.sv
// UART RX front end: line synchroniser, oversample counters and 3-sample mid-bit majority vote.
// Latency: RX_SYNC = RX_IN + SYNC_STAGES cycles; SAMPLE_VALID strobes the cycle after EDGE_COUNT == PRESCALE/2+2.
// Backpressure: none; the FSM gates everything with COUNTER_EN / DATA_SAMP_EN and the strobe is not held.
// Ports: CLK, RST (sync, active-low) plain; bus (slave modport) carries RX_IN, the FSM enables
//        and RX_SYNC, EDGE_COUNT, BIT_COUNT, SAMPLED_BIT, SAMPLE_VALID, NOISE_FLAG.
module rx_data_sampler import uart_rx_pkg::*; #(
   parameter int PRESCALE    = PRESCALE_DEF,
   parameter int EDGE_W      = EDGE_W_DEF,
   parameter int BIT_W       = BIT_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic               CLK,
   input  logic               RST,
   rx_data_sampler_if.slave   bus
);

   localparam int MID = PRESCALE / 2;

   // Sample edges straddle mid-bit; the vote happens on the edge after the last sample.
   localparam logic [EDGE_W-1:0] SAMP_E0  = EDGE_W'(MID - 1);
   localparam logic [EDGE_W-1:0] SAMP_E1  = EDGE_W'(MID);
   localparam logic [EDGE_W-1:0] SAMP_E2  = EDGE_W'(MID + 1);
   localparam logic [EDGE_W-1:0] DECIDE_E = EDGE_W'(MID + 2);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [2:0]             samp_q;
   logic [2:0]             got_q;
   logic                   sampled_bit_q;
   logic                   sample_valid_q;
   logic                   noise_flag_q;
   logic                   rx_sync;
   logic                   win_en;

   assign rx_sync = sync_q[SYNC_STAGES-1];
   // Both enables are needed: a stopped counter must also cancel a pending vote.
   assign win_en  = bus.COUNTER_EN && bus.DATA_SAMP_EN;

   rx_edge_bit_counter #(
      .PRESCALE (PRESCALE),
      .EDGE_W   (EDGE_W),
      .BIT_W    (BIT_W)
   ) u_counter (
      .CLK        (CLK),
      .RST        (RST),
      .COUNTER_EN (bus.COUNTER_EN),
      .EDGE_COUNT (bus.EDGE_COUNT),
      .BIT_COUNT  (bus.BIT_COUNT)
   );

   // MSB is the oldest stage and feeds everything downstream.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         sync_q <= {SYNC_STAGES{IDLE_LINE}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.RX_IN};
      end
   end

   // got_q tracks which slots were filled inside the current enabled window, so a window
   // broken by an enable drop never votes with leftover samples.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         samp_q         <= 3'b111;
         got_q          <= 3'b000;
         sampled_bit_q  <= IDLE_LINE;
         sample_valid_q <= 1'b0;
         noise_flag_q   <= 1'b0;
      end else begin
         sample_valid_q <= 1'b0;
         if (!win_en) begin
            samp_q <= 3'b111;
            got_q  <= 3'b000;
         end else begin
            if (bus.EDGE_COUNT == SAMP_E0) begin
               samp_q[0] <= rx_sync;
               got_q[0]  <= 1'b1;
            end
            if (bus.EDGE_COUNT == SAMP_E1) begin
               samp_q[1] <= rx_sync;
               got_q[1]  <= 1'b1;
            end
            if (bus.EDGE_COUNT == SAMP_E2) begin
               samp_q[2] <= rx_sync;
               got_q[2]  <= 1'b1;
            end
            if ((bus.EDGE_COUNT == DECIDE_E) && (got_q == 3'b111)) begin
               sampled_bit_q  <= maj3(samp_q);
               noise_flag_q   <= !unanimous3(samp_q);
               sample_valid_q <= 1'b1;
               got_q          <= 3'b000;
            end
         end
      end
   end

   assign bus.RX_SYNC      = rx_sync;
   assign bus.SAMPLED_BIT  = sampled_bit_q;
   assign bus.SAMPLE_VALID = sample_valid_q;
   assign bus.NOISE_FLAG   = noise_flag_q;

endmodule

// File: tb/tb_rx_data_sampler.sv
// Bench for rx_data_sampler: directed frames plus randomized line/enable traffic.
// Latency: outputs checked each cycle on the falling edge after the inputs take effect.
// Backpressure: none; inputs are driven on the falling edge.
module tb_rx_data_sampler;
   import uart_rx_pkg::*;

   localparam int P   = 8;
   localparam int EW  = 4;
   localparam int BW  = 4;
   localparam int SS  = 2;
   localparam int MID = P / 2;
   localparam int BMAX = (1 << BW) - 1;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   rx_data_sampler_if #(.EDGE_W(EW), .BIT_W(BW)) bus ();

   rx_data_sampler #(
      .PRESCALE    (P),
      .EDGE_W      (EW),
      .BIT_W       (BW),
      .SYNC_STAGES (SS)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // Reference model: run = edges since the counters were last enabled, a delay line for the
   // synchroniser, and a 4-entry history of (window active, edge index, synced line).
   typedef struct packed {
      logic       act;
      logic [7:0] e;
      logic       rs;
   } ent_t;

   int   run = 0;
   logic sync_m[$];
   ent_t hist[$];
   logic m_bit   = 1'b1;
   logic m_valid = 1'b0;
   logic m_noise = 1'b0;

   // Strobes seen on the DUT, for the directed sequence checks.
   logic st_bit[$];
   logic st_noise[$];
   int   st_edge[$];

   task automatic step(input logic rst_v, input logic ce, input logic dse, input logic rxin);
      ent_t en;
      int   ones;
      bit   win_ok;
      RST              = rst_v;
      bus.COUNTER_EN   = ce;
      bus.DATA_SAMP_EN = dse;
      bus.RX_IN        = rxin;

      en.act = rst_v && ce && dse;
      en.e   = 8'(run % P);
      en.rs  = sync_m[0];
      hist.push_back(en);
      if (hist.size() > 4) void'(hist.pop_front());

      m_valid = 1'b0;
      win_ok  = (hist.size() == 4);
      for (int k = 0; k < 4; k++) begin
         if (win_ok && (!hist[k].act || int'(hist[k].e) != MID - 1 + k)) win_ok = 0;
      end
      if (win_ok) begin
         ones    = int'(hist[0].rs) + int'(hist[1].rs) + int'(hist[2].rs);
         m_bit   = (ones >= 2);
         m_noise = (ones == 1) || (ones == 2);
         m_valid = 1'b1;
      end
      if (!rst_v) begin
         m_bit = 1'b1; m_noise = 1'b0; m_valid = 1'b0;
      end
      run = (rst_v && ce) ? run + 1 : 0;
      if (!rst_v) begin
         sync_m.delete();
         for (int k = 0; k < SS; k++) sync_m.push_back(1'b1);
      end else begin
         void'(sync_m.pop_front());
         sync_m.push_back(rxin);
      end

      @(posedge CLK);
      @(negedge CLK);
      cyc++;
      check_eq("rx_sync",      32'(bus.RX_SYNC),      32'(sync_m[0]));
      check_eq("edge_count",   32'(bus.EDGE_COUNT),   32'(run % P));
      check_eq("bit_count",    32'(bus.BIT_COUNT),    32'((run / P > BMAX) ? BMAX : run / P));
      check_eq("sampled_bit",  32'(bus.SAMPLED_BIT),  32'(m_bit));
      check_eq("sample_valid", 32'(bus.SAMPLE_VALID), 32'(m_valid));
      check_eq("noise_flag",   32'(bus.NOISE_FLAG),   32'(m_noise));
      if (bus.SAMPLE_VALID === 1'b1) begin
         st_bit.push_back(bus.SAMPLED_BIT);
         st_noise.push_back(bus.NOISE_FLAG);
         st_edge.push_back(int'(bus.EDGE_COUNT));
      end
   endtask

   task automatic clear_strobes();
      st_bit.delete();
      st_noise.delete();
      st_edge.delete();
   endtask

   // Sends nbits bit periods starting with the counters at 0. glitch_bit gets a one-cycle low
   // pulse landing on synced edge MID; abort_bit has DATA_SAMP_EN low from edge MID onwards.
   task automatic send_bits(input logic [15:0] bits, input int nbits,
                            input int glitch_bit, input int abort_bit);
      logic rx;
      logic dse;
      for (int b = 0; b < nbits; b++) begin
         for (int o = 0; o < P; o++) begin
            rx  = bits[b];
            if (b == glitch_bit && o == MID - SS) rx = 1'b0;
            dse = !(b == abort_bit && o >= MID);
            step(1'b1, 1'b1, dse, rx);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, IDLE_LINE);
   endtask

   logic [15:0] frame;
   logic        r_rst, r_ce, r_dse, r_rx, rx_g;

   initial begin
      for (int k = 0; k < SS; k++) sync_m.push_back(1'b1);
      bus.RX_IN        = 1'b1;
      bus.COUNTER_EN   = 1'b0;
      bus.DATA_SAMP_EN = 1'b0;

      // Reset with the line toggling and enables high.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'(i % 2));
      idle(4);

      // Clean frame: start 0, 0xA5 LSB-first, stop 1.
      clear_strobes();
      frame = {6'b0, 1'b1, 8'hA5, 1'b0};
      send_bits(frame, 10, -1, -1);
      check_eq("frame_strobes", 32'(st_bit.size()), 32'd10);
      check_eq("frame_bits", {22'd0, st_bit[9], st_bit[8], st_bit[7], st_bit[6], st_bit[5],
                              st_bit[4], st_bit[3], st_bit[2], st_bit[1], st_bit[0]},
               32'b1101001010);
      for (int i = 0; i < st_edge.size(); i++) begin
         check_eq("frame_edge", 32'(st_edge[i]), 32'd7);
         check_eq("frame_noise", 32'(st_noise[i]), 32'd0);
      end
      check_eq("frame_bitcnt", 32'(bus.BIT_COUNT), 32'(STOP_BIT_PAR));
      idle(3);

      // Glitch on the middle sample of a '1' bit.
      clear_strobes();
      send_bits(16'h0007, 3, 1, -1);
      check_eq("glitch_strobes", 32'(st_bit.size()), 32'd3);
      check_eq("glitch_bits", {29'd0, st_bit[2], st_bit[1], st_bit[0]}, 32'b111);
      check_eq("glitch_noise", {29'd0, st_noise[2], st_noise[1], st_noise[0]}, 32'b010);
      idle(3);

      // Saturation, then drop COUNTER_EN at edge 3.
      for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
      check_eq("sat_bitcnt", 32'(bus.BIT_COUNT), 32'd15);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
      check_eq("pre_drop_edge", 32'(bus.EDGE_COUNT), 32'd3);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check_eq("drop_edge", 32'(bus.EDGE_COUNT), 32'(START_BIT));
      check_eq("drop_bit", 32'(bus.BIT_COUNT), 32'(START_BIT));
      check_eq("drop_valid", 32'(bus.SAMPLE_VALID), 32'd0);

      // Drop COUNTER_EN exactly on the decision edge: the vote must be cancelled.
      for (int i = 0; i < MID + 2; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("cancel_valid", 32'(bus.SAMPLE_VALID), 32'd0);
      check_eq("cancel_bit_hold", 32'(bus.SAMPLED_BIT), 32'd1);
      idle(3);

      // DATA_SAMP_EN abort in bit 1; bit 2 must strobe normally.
      clear_strobes();
      send_bits(16'h0006, 3, -1, 1);
      check_eq("abort_strobes", 32'(st_bit.size()), 32'd2);
      check_eq("abort_bits", {30'd0, st_bit[1], st_bit[0]}, 32'b10);
      idle(3);

      // Reset mid-frame at BIT_COUNT=5, EDGE_COUNT=4.
      send_bits(16'h0015, 5, -1, -1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
      check_eq("pre_rst_bit", 32'(bus.BIT_COUNT), 32'd5);
      check_eq("pre_rst_edge", 32'(bus.EDGE_COUNT), 32'd4);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("rst_edge", 32'(bus.EDGE_COUNT), 32'd0);
      check_eq("rst_bit", 32'(bus.BIT_COUNT), 32'd0);
      check_eq("rst_sampled", 32'(bus.SAMPLED_BIT), 32'd1);
      check_eq("rst_valid", 32'(bus.SAMPLE_VALID), 32'd0);
      check_eq("rst_noise", 32'(bus.NOISE_FLAG), 32'd0);
      check_eq("rst_sync", 32'(bus.RX_SYNC), 32'd1);

      // Randomized traffic against the model.
      r_ce = 1'b1; r_dse = 1'b1; r_rx = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         r_rst = ($urandom_range(0, 249) != 0);
         if ($urandom_range(0, 59) == 0) r_ce = !r_ce;
         if ($urandom_range(0, 29) == 0) r_dse = !r_dse;
         if ($urandom_range(0, 7) == 0) r_rx = 1'($urandom_range(0, 1));
         rx_g = r_rx;
         if ($urandom_range(0, 11) == 0) rx_g = !r_rx;
         step(r_rst, r_ce, r_dse, rx_g);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_data_sampler.md
Name: rx_data_sampler

Overview:
- Front-end timing stage of the UART receiver. It synchronises the serial line and runs the oversampling edge/bit counters that the RX control FSM sequences on.
- It takes three majority-vote samples around mid-bit and presents one recovered bit per bit period to the deserializer, parity check and start/stop check blocks.
- Enables come from the RX FSM. Counts and the sampled bit go back to the FSM and forward to the checkers.

Parameters:
- PRESCALE, 8, oversampling clocks per bit; legal range 6..16.
- EDGE_W, 4, width of the edge counter.
- BIT_W, 4, width of the bit counter.
- SYNC_STAGES, 2, flops in the RX_IN synchroniser; legal 2..3.

Ports:
- CLK  in  1  oversampling clock.
- RST  in  1  synchronous, active-low reset.
- RX_IN  in  1  raw serial line, asynchronous to CLK; idle high.
- COUNTER_EN  in  1  from FSM; 1 = run edge/bit counters, 0 = hold both at 0.
- DATA_SAMP_EN  in  1  from FSM; 1 = sampling window active.
- RX_SYNC  out  1  synchronised RX_IN, offered to the FSM for start detection.
- EDGE_COUNT  out  EDGE_W  current oversample edge index within the bit, 0..PRESCALE-1.
- BIT_COUNT  out  BIT_W  current bit index within the frame, start bit = 0.
- SAMPLED_BIT  out  1  majority-voted value of the most recent bit.
- SAMPLE_VALID  out  1  one-cycle strobe; SAMPLED_BIT was updated this cycle.
- NOISE_FLAG  out  1  qualifies SAMPLE_VALID; the three samples were not unanimous.

Behaviour:
- Reset is synchronous and active-low: all logic sees RST=0 only at a CLK rising edge. Reset values:
  - Synchroniser flops = 1; RX_SYNC = 1.
  - EDGE_COUNT = 0, BIT_COUNT = 0.
  - SAMPLED_BIT = 1, SAMPLE_VALID = 0, NOISE_FLAG = 0.
  - Sample registers = 3'b111.
- Synchroniser: RX_SYNC is RX_IN delayed by SYNC_STAGES cycles. All sampling uses RX_SYNC, never RX_IN.
- Counters:
  - COUNTER_EN=0: EDGE_COUNT <= 0 and BIT_COUNT <= 0 on the next edge, regardless of the prior value.
  - COUNTER_EN=1, EDGE_COUNT < PRESCALE-1: EDGE_COUNT <= EDGE_COUNT+1.
  - COUNTER_EN=1, EDGE_COUNT == PRESCALE-1: EDGE_COUNT <= 0 and BIT_COUNT <= BIT_COUNT+1.
  - BIT_COUNT saturates at 2^BIT_W-1. It never wraps to 0.
  - Both counts are registered outputs. The FSM compares them combinationally.
- Sample window (M = PRESCALE/2, integer division):
  - Sample edges are M-1, M and M+1.
  - When DATA_SAMP_EN=1 and EDGE_COUNT equals sample edge k, register RX_SYNC into sample slot k (k = 0..2).
  - At EDGE_COUNT == M+2 with DATA_SAMP_EN=1:
    - SAMPLED_BIT <= majority(s0,s1,s2).
    - SAMPLE_VALID <= 1 for exactly one cycle.
    - NOISE_FLAG <= (s0,s1,s2 not all equal).
  - Result latency: SAMPLE_VALID is high in the cycle after EDGE_COUNT == M+2, i.e. one strobe per bit period.
  - For PRESCALE=8: samples at edges 3,4,5; decision at edge 6; SAMPLE_VALID high while EDGE_COUNT == 7.
  - For PRESCALE=6: samples at 2,3,4; decision at 5; SAMPLE_VALID high while EDGE_COUNT == 0 of the next bit.
- DATA_SAMP_EN=0:
  - No sample capture, SAMPLE_VALID = 0.
  - Sample registers reload 3'b111.
  - SAMPLED_BIT and NOISE_FLAG hold their last value.
- DATA_SAMP_EN dropping mid-window: the partial samples are discarded and no strobe is issued for that bit.
- COUNTER_EN dropping mid-bit: counters clear next cycle, and any pending decision is cancelled.
- Reset mid-frame: every register returns to its reset value on that edge, with no strobe in the reset cycle.
- SAMPLE_VALID never rises while RST=0, COUNTER_EN=0 or DATA_SAMP_EN=0.

Decomposition:
- Shared package uart_rx_pkg holds:
  - Default PRESCALE, EDGE_W, BIT_W.
  - IDLE_LINE = 1'b1.
  - The frame bit-index constants START_BIT=0, FIRST_DATA=1, PARITY_BIT=9, STOP_BIT_PAR=10; these are also used by the RX FSM.
- One sub-module: rx_edge_bit_counter, containing the EDGE/BIT counters and the saturation rule.
- Synchroniser, sample window and majority vote stay in the top.

Test Plan:
- Reset: hold RST=0 for 3 cycles with RX_IN toggling -> RX_SYNC=1, EDGE_COUNT=0, BIT_COUNT=0, SAMPLED_BIT=1, SAMPLE_VALID=0 throughout.
- Clean frame, PRESCALE=8: COUNTER_EN=DATA_SAMP_EN=1, drive 0x A5 LSB-first framed with start 0 and stop 1 -> 10 SAMPLE_VALID strobes, each with EDGE_COUNT=7; SAMPLED_BIT sequence 0,1,0,1,0,0,1,0,1,1; NOISE_FLAG=0; BIT_COUNT reaches 10.
- Glitch: single-cycle low pulse on synced edge 4 of a '1' bit -> SAMPLED_BIT=1, NOISE_FLAG=1 on that strobe only.
- Counter control: COUNTER_EN=1 for 200 cycles -> BIT_COUNT saturates at 15 and never wraps; then drop COUNTER_EN at EDGE_COUNT=3 -> EDGE_COUNT=0, BIT_COUNT=0 next cycle, no SAMPLE_VALID.
- Enable abort: DATA_SAMP_EN drops at edge 4 -> no strobe for that bit, SAMPLED_BIT unchanged; re-enable -> next bit strobes normally.
- Reset mid-frame: assert RST=0 at BIT_COUNT=5, EDGE_COUNT=4 -> all outputs at reset values on the next edge, and no strobe is emitted in that cycle.
